// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs big-endian words
// and writes them into the instruction memory while holding the CPU in reset.
module imem_loader #(
  parameter int Nloc  = 512,
  parameter int Dbits = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    mem_we,
  output logic [$clog2(Nloc)-1:0] mem_addr,
  output logic [Dbits-1:0]        mem_wdata,
  output logic                    cpu_hold,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [$clog2(Nloc):0]   words_loaded
);

  localparam int AW  = $clog2(Nloc);
  localparam int WLW = AW + 1;
  localparam int BPW = Dbits / 8;
  localparam int BW  = $clog2(BPW) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]       state_reg, state_next;
  logic [15:0]      len_reg, len_next;
  logic [BW-1:0]    byte_cnt_reg, byte_cnt_next;
  logic [Dbits-1:0] word_reg, word_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [WLW-1:0]   wl_reg, wl_next;
  logic             hold_reg, hold_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;

  logic             xfer;
  logic [15:0]      len_full;
  logic [WLW-1:0]   wl_inc;

  assign rx_ready = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                    (state_reg == S_DATA);
  assign xfer     = rx_valid && rx_ready;
  assign len_full = {len_reg[15:8], rx_data};
  assign wl_inc   = wl_reg + WLW'(1);

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    word_next     = word_reg;
    addr_next     = addr_reg;
    wl_next       = wl_reg;
    hold_next     = hold_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    error_next    = error_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next    = S_LEN_HI;
          hold_next     = 1'b1;
          busy_next     = 1'b1;
          done_next     = 1'b0;
          error_next    = 1'b0;
          wl_next       = '0;
          addr_next     = '0;
          byte_cnt_next = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_next   = {rx_data, 8'h00};
          state_next = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_next = len_full;
          if (len_full == 16'd0 || 32'(len_full) > 32'(Nloc)) begin
            state_next = S_ERROR;
            error_next = 1'b1;
            busy_next  = 1'b0;
          end else begin
            state_next    = S_DATA;
            byte_cnt_next = '0;
            addr_next     = '0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_next = (word_reg << 8) | Dbits'(rx_data);
          if (byte_cnt_reg == BW'(BPW - 1)) begin
            byte_cnt_next = '0;
            state_next    = S_WRITE;
          end else begin
            byte_cnt_next = byte_cnt_reg + BW'(1);
          end
        end
      end
      S_WRITE: begin
        wl_next = wl_inc;
        // Address is left on the last word at completion so it never wraps.
        if (32'(wl_inc) == 32'(len_reg)) begin
          state_next = S_DONE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          hold_next  = 1'b0;
        end else begin
          addr_next  = addr_reg + AW'(1);
          state_next = S_DATA;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      word_reg     <= '0;
      addr_reg     <= '0;
      wl_reg       <= '0;
      hold_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      word_reg     <= word_next;
      addr_reg     <= addr_next;
      wl_reg       <= wl_next;
      hold_reg     <= hold_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  assign mem_we       = (state_reg == S_WRITE);
  assign mem_addr     = addr_reg;
  assign mem_wdata    = word_reg;
  assign cpu_hold     = hold_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign error        = error_reg;
  assign words_loaded = wl_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a word-list reference model built from the
// byte stream is compared against every observed memory write and status flag.
module tb_imem_loader;
  localparam int NLOC  = 512;
  localparam int DBITS = 32;
  localparam int BPW   = DBITS / 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold, busy, done, error;
  logic [9:0]  words_loaded;

  imem_loader #(.Nloc(NLOC), .Dbits(DBITS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    longint      cyc;
  } wr_t;

  int          n_vec = 0;
  int          n_err = 0;
  longint      cyc = 0;
  wr_t         got[$];
  byte unsigned pay[$];
  int          noise = 0;
  bit          timeout = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got.push_back('{addr: int'(mem_addr), data: mem_wdata, cyc: cyc});
      chk("ready_in_write", 64'(rx_ready), 64'd0);
    end
  end

  task automatic check_zero(input string where);
    chk({where, "_ready"}, 64'(rx_ready), 0);
    chk({where, "_we"},    64'(mem_we), 0);
    chk({where, "_addr"},  64'(mem_addr), 0);
    chk({where, "_wdata"}, 64'(mem_wdata), 0);
    chk({where, "_hold"},  64'(cpu_hold), 0);
    chk({where, "_busy"},  64'(busy), 0);
    chk({where, "_done"},  64'(done), 0);
    chk({where, "_error"}, 64'(error), 0);
    chk({where, "_wl"},    64'(words_loaded), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (noise != 0) start = ($urandom_range(3) == 0);
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        if (rx_ready) begin
          @(posedge clk);
          #1;
          rx_valid = 1'b0;
          start    = 1'b0;
          return;
        end
      end
    end
    timeout  = 1'b1;
    rx_valid = 1'b0;
    start    = 1'b0;
    chk("rx_timeout", 1, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference: a valid header yields len words, word w = bytes 4w..4w+3 big-endian.
  task automatic do_load(input int len, input int gap_pct, input int use_noise, input bit randpay);
    logic [31:0] exp_w[$];
    logic [31:0] wv;
    int          n;
    got.delete();
    timeout = 1'b0;
    pulse_start();
    chk("start_busy", 64'(busy), 1);
    chk("start_hold", 64'(cpu_hold), 1);
    chk("start_done_clr", 64'(done), 0);
    chk("start_wl_clr", 64'(words_loaded), 0);
    send_byte(len[15:8], gap_pct);
    send_byte(len[7:0], gap_pct);
    if (len == 0 || len > NLOC) begin
      chk("err_flag", 64'(error), 1);
      chk("err_hold", 64'(cpu_hold), 1);
      chk("err_busy", 64'(busy), 0);
      chk("err_ready", 64'(rx_ready), 0);
      repeat (3) @(negedge clk);
      chk("err_nowrite", 64'(got.size()), 0);
      chk("err_done", 64'(done), 0);
      $display("load len=%0d rejected error=%0d hold=%0d", len, error, cpu_hold);
      return;
    end
    if (randpay) begin
      pay.delete();
      for (int i = 0; i < len * BPW; i++) pay.push_back(8'($urandom));
    end
    for (int w = 0; w < len; w++) begin
      wv = '0;
      for (int j = 0; j < BPW; j++) wv = (wv << 8) | 32'(pay[w * BPW + j]);
      exp_w.push_back(wv);
    end
    noise = use_noise;
    foreach (pay[i]) begin
      send_byte(pay[i], gap_pct);
      if (timeout) break;
    end
    noise = 0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk("fin_done", 64'(done), 1);
    chk("fin_error", 64'(error), 0);
    chk("fin_hold", 64'(cpu_hold), 0);
    chk("fin_busy", 64'(busy), 0);
    chk("fin_ready", 64'(rx_ready), 0);
    chk("fin_wl", 64'(words_loaded), 64'(len));
    chk("fin_nwrites", 64'(got.size()), 64'(len));
    n = (got.size() < len) ? got.size() : len;
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", 64'(got[i].addr), 64'(i));
      chk("wr_data", 64'(got[i].data), 64'(exp_w[i]));
    end
    $display("load len=%0d gap=%0d noise=%0d writes=%0d done=%0d", len, gap_pct, use_noise, got.size(), done);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    byte unsigned t1[8]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    byte unsigned t2[4]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    repeat (3) @(negedge clk);
    check_zero("rst");
    reset_n = 1'b1;

    pay.delete();
    foreach (t1[i]) pay.push_back(t1[i]);
    do_load(2, 0, 0, 1'b0);
    chk("t1_gap", (got.size() >= 2) ? 64'(got[1].cyc - got[0].cyc) : 64'd0, 5);
    chk("t1_w0", (got.size() >= 1) ? 64'(got[0].data) : 64'd0, 64'hDEADBEEF);
    chk("t1_w1", (got.size() >= 2) ? 64'(got[1].data) : 64'd0, 64'h12345678);

    do_load(0, 0, 0, 1'b0);
    pay.delete();
    foreach (t2[i]) pay.push_back(t2[i]);
    do_load(1, 0, 0, 1'b0);
    chk("t2_w0", (got.size() >= 1) ? 64'(got[0].data) : 64'd0, 64'hAABBCCDD);

    do_load(NLOC + 1, 0, 0, 1'b1);
    do_load(NLOC, 0, 0, 1'b1);
    chk("full_last_addr", (got.size() > 0) ? 64'(got[got.size() - 1].addr) : 64'd0, NLOC - 1);

    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(24, 1);
      do_load(len, 50, k % 2, 1'b1);
    end
    do_load($urandom_range(65535, NLOC + 1), 30, 0, 1'b1);

    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    reset_n = 1'b1;
    do_load(2, 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
